uart_ctrl: RTL and testbench

Single-clock UART controller between the processor datapath and the serial pins. Store-side writes are queued in a TX FIFO and serialized 8N1. Received frames are deserialized into an RX FIFO that the datapath pops through its UART read path. It owns all baud timing, framing and buffering so the single-cycle core never stalls on serial I/O.

---
 rtl/uart_ctrl.sv | 277 +++++++++++++++++++++++++++
 tb/tb_uart_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_ctrl.sv
// uart_ctrl: single-clock 8N1 UART with TX/RX circular FIFOs, sticky
// overrun / framing error flags and an optional internal loopback.
// Optional feature macro: UART_LOOPBACK_EN (RX synchronizer fed from UART_TX).
module uart_ctrl #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        UART_WRITE_EN,
  input  logic [7:0]  TX_DATA,
  input  logic        UART_READ_EN,
  output logic [31:0] UART_READ_DATA,
  input  logic        STATUS_CLR,
  input  logic        UART_RX,
  output logic        UART_TX,
  output logic        TX_FULL,
  output logic        RX_EMPTY,
  output logic        TX_BUSY,
  output logic        RX_OVERRUN,
  output logic        FRAME_ERR
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  // ---------------- TX FIFO ----------------
  logic [7:0]       tx_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] tx_wr_ptr, tx_rd_ptr;
  logic [CNT_W-1:0] tx_count;
  logic             tx_pop_c, tx_push_c;

  assign tx_push_c = UART_WRITE_EN && ((tx_count != FULL_CNT) || tx_pop_c);

  // TX FIFO storage
  always_ff @(posedge clk) begin
    if (tx_push_c) tx_mem[tx_wr_ptr] <= TX_DATA;
  end

  // TX FIFO pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else begin
      if (tx_push_c) tx_wr_ptr <= tx_wr_ptr + PTR_W'(1);
      if (tx_pop_c)  tx_rd_ptr <= tx_rd_ptr + PTR_W'(1);
      case ({tx_push_c, tx_pop_c})
        2'b10:   tx_count <= tx_count + CNT_W'(1);
        2'b01:   tx_count <= tx_count - CNT_W'(1);
        default: tx_count <= tx_count;
      endcase
    end
  end

  // ---------------- TX FSM ----------------
  state_t            tx_state, tx_next;
  logic [BAUD_W-1:0] tx_cnt, tx_cnt_d;
  logic [2:0]        tx_bit, tx_bit_d;
  logic [7:0]        tx_shift, tx_shift_d;
  logic              tx_line, tx_line_d;
  logic              tx_cell_end_c;

  assign tx_cell_end_c = (tx_cnt == BAUD_LAST);

  // TX state and datapath registers; line idles high
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_line  <= 1'b1;
    end else begin
      tx_state <= tx_next;
      tx_cnt   <= tx_cnt_d;
      tx_bit   <= tx_bit_d;
      tx_shift <= tx_shift_d;
      tx_line  <= tx_line_d;
    end
  end

  // TX next-state
  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      S_IDLE:  if (tx_count != '0) tx_next = S_START;
      S_START: if (tx_cell_end_c) tx_next = S_DATA;
      S_DATA:  if (tx_cell_end_c && (tx_bit == 3'd7)) tx_next = S_STOP;
      S_STOP:  if (tx_cell_end_c) tx_next = S_IDLE;
      default: tx_next = S_IDLE;
    endcase
  end

  // TX outputs: FIFO pop, counters, shifter and the next line level
  always_comb begin
    tx_pop_c   = 1'b0;
    tx_cnt_d   = tx_cnt + BAUD_W'(1);
    tx_bit_d   = tx_bit;
    tx_shift_d = tx_shift;
    case (tx_state)
      S_IDLE: begin
        tx_cnt_d = '0;
        if (tx_count != '0) begin
          tx_pop_c   = 1'b1;
          tx_shift_d = tx_mem[tx_rd_ptr];
        end
      end
      S_START: begin
        if (tx_cell_end_c) begin
          tx_cnt_d = '0;
          tx_bit_d = '0;
        end
      end
      S_DATA: begin
        if (tx_cell_end_c) begin
          tx_cnt_d   = '0;
          tx_bit_d   = tx_bit + 3'd1;
          tx_shift_d = {1'b0, tx_shift[7:1]};
        end
      end
      S_STOP: begin
        if (tx_cell_end_c) tx_cnt_d = '0;
      end
      default: tx_cnt_d = '0;
    endcase
    // Line is registered from the next state so START begins on the pop edge
    case (tx_next)
      S_START: tx_line_d = 1'b0;
      S_DATA:  tx_line_d = tx_shift_d[0];
      default: tx_line_d = 1'b1;
    endcase
  end

  // ---------------- RX synchronizer ----------------
  logic rx_pin_c, rx_meta, rx_sync;

`ifdef UART_LOOPBACK_EN
  logic unused_rx_pin_c;
  assign unused_rx_pin_c = UART_RX;
  assign rx_pin_c        = tx_line;
`else
  assign rx_pin_c = UART_RX;
`endif

  // Two-flop synchronizer, idles high like the line
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx_pin_c;
      rx_sync <= rx_meta;
    end
  end

  // ---------------- RX FSM ----------------
  state_t            rx_state, rx_next;
  logic [BAUD_W-1:0] rx_cnt, rx_cnt_d;
  logic [2:0]        rx_bit, rx_bit_d;
  logic [7:0]        rx_shift, rx_shift_d;
  logic              rx_push_c, ferr_set_c;
  logic              rx_cell_end_c;

  assign rx_cell_end_c = (rx_cnt == BAUD_LAST);

  // RX state and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state <= S_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_state <= rx_next;
      rx_cnt   <= rx_cnt_d;
      rx_bit   <= rx_bit_d;
      rx_shift <= rx_shift_d;
    end
  end

  // RX next-state; a high line at mid-start is a false start
  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      S_IDLE:  if (!rx_sync) rx_next = S_START;
      S_START: if (rx_cnt == HALF_LAST) rx_next = rx_sync ? S_IDLE : S_DATA;
      S_DATA:  if (rx_cell_end_c && (rx_bit == 3'd7)) rx_next = S_STOP;
      S_STOP:  if (rx_cell_end_c) rx_next = S_IDLE;
      default: rx_next = S_IDLE;
    endcase
  end

  // RX outputs: counters, shifter, push request and framing error
  always_comb begin
    rx_cnt_d   = rx_cnt + BAUD_W'(1);
    rx_bit_d   = rx_bit;
    rx_shift_d = rx_shift;
    rx_push_c  = 1'b0;
    ferr_set_c = 1'b0;
    case (rx_state)
      S_IDLE: rx_cnt_d = '0;
      S_START: begin
        if (rx_cnt == HALF_LAST) begin
          rx_cnt_d = '0;
          rx_bit_d = '0;
        end
      end
      S_DATA: begin
        if (rx_cell_end_c) begin
          rx_cnt_d   = '0;
          rx_bit_d   = rx_bit + 3'd1;
          rx_shift_d = {rx_sync, rx_shift[7:1]};
        end
      end
      S_STOP: begin
        if (rx_cell_end_c) begin
          rx_cnt_d   = '0;
          rx_push_c  = rx_sync;
          ferr_set_c = !rx_sync;
        end
      end
      default: rx_cnt_d = '0;
    endcase
  end

  // ---------------- RX FIFO ----------------
  logic [7:0]       rx_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rx_wr_ptr, rx_rd_ptr;
  logic [CNT_W-1:0] rx_count;
  logic             rx_pop_c, rx_push_ok_c, ovr_set_c;

  assign rx_pop_c     = UART_READ_EN && (rx_count != '0);
  assign rx_push_ok_c = rx_push_c && ((rx_count != FULL_CNT) || rx_pop_c);
  assign ovr_set_c    = rx_push_c && !rx_push_ok_c;

  // RX FIFO storage
  always_ff @(posedge clk) begin
    if (rx_push_ok_c) rx_mem[rx_wr_ptr] <= rx_shift;
  end

  // RX FIFO pointers, occupancy and sticky flags (set beats clear)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_wr_ptr  <= '0;
      rx_rd_ptr  <= '0;
      rx_count   <= '0;
      RX_OVERRUN <= 1'b0;
      FRAME_ERR  <= 1'b0;
    end else begin
      if (rx_push_ok_c) rx_wr_ptr <= rx_wr_ptr + PTR_W'(1);
      if (rx_pop_c)     rx_rd_ptr <= rx_rd_ptr + PTR_W'(1);
      case ({rx_push_ok_c, rx_pop_c})
        2'b10:   rx_count <= rx_count + CNT_W'(1);
        2'b01:   rx_count <= rx_count - CNT_W'(1);
        default: rx_count <= rx_count;
      endcase
      RX_OVERRUN <= ovr_set_c  | (RX_OVERRUN & ~STATUS_CLR);
      FRAME_ERR  <= ferr_set_c | (FRAME_ERR  & ~STATUS_CLR);
    end
  end

  // Status and read-path outputs derived from registered state
  assign UART_TX        = tx_line;
  assign TX_FULL        = (tx_count == FULL_CNT);
  assign RX_EMPTY       = (rx_count == '0);
  assign TX_BUSY        = (tx_state != S_IDLE) || (tx_count != '0);
  assign UART_READ_DATA = (rx_count != '0) ? {24'h0, rx_mem[rx_rd_ptr]} : 32'hFFFF_FFFF;

endmodule

// File: tb/tb_uart_ctrl.sv
// tb_uart_ctrl: directed self-checking bench for uart_ctrl (CLKS_PER_BIT=4, FIFO_DEPTH=4).
`timescale 1ns/1ps
module tb_uart_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        UART_WRITE_EN = 1'b0;
  logic [7:0]  TX_DATA = 8'h00;
  logic        UART_READ_EN = 1'b0;
  logic [31:0] UART_READ_DATA;
  logic        STATUS_CLR = 1'b0;
  logic        UART_RX = 1'b1;
  logic        UART_TX, TX_FULL, RX_EMPTY, TX_BUSY, RX_OVERRUN, FRAME_ERR;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  uart_ctrl #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .UART_WRITE_EN(UART_WRITE_EN), .TX_DATA(TX_DATA),
    .UART_READ_EN(UART_READ_EN), .UART_READ_DATA(UART_READ_DATA),
    .STATUS_CLR(STATUS_CLR), .UART_RX(UART_RX), .UART_TX(UART_TX),
    .TX_FULL(TX_FULL), .RX_EMPTY(RX_EMPTY), .TX_BUSY(TX_BUSY),
    .RX_OVERRUN(RX_OVERRUN), .FRAME_ERR(FRAME_ERR)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Waits for a start bit, then samples mid-cell; returns after the mid-stop sample
  task automatic tx_frame(input string tag, output logic [9:0] cells, output int t_start);
    bit found = 0;
    cells = '0;
    t_start = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (UART_TX == 1'b0) begin
        found = 1;
        break;
      end
    end
    check({tag, "_start_seen"}, 32'(found), 32'd1);
    if (!found) return;
    t_start = cyc;
    repeat (2) @(negedge clk);
    cells[0] = UART_TX;
    for (int c = 1; c < 10; c++) begin
      repeat (4) @(negedge clk);
      cells[c] = UART_TX;
    end
  endtask

  task automatic write_byte(input logic [7:0] b);
    @(negedge clk);
    UART_WRITE_EN = 1'b1;
    TX_DATA = b;
    @(negedge clk);
    UART_WRITE_EN = 1'b0;
  endtask

  // Drives one 8N1 frame on UART_RX, 4 cycles per bit, then idles high
  task automatic rx_send(input logic [7:0] b, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      UART_RX = f[i];
      repeat (3) @(negedge clk);
    end
    @(negedge clk);
    UART_RX = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic pop_rx();
    @(negedge clk);
    UART_READ_EN = 1'b1;
    @(negedge clk);
    UART_READ_EN = 1'b0;
  endtask

  task automatic clear_status();
    @(negedge clk);
    STATUS_CLR = 1'b1;
    @(negedge clk);
    STATUS_CLR = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] cells;
    logic [9:0] exp_cells;
    logic [7:0] exp_b;
    int t_start, t_wr;

    // Reset and idle
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (50) @(negedge clk);
    check("rst_tx", 32'(UART_TX), 32'd1);
    check("rst_rx_empty", 32'(RX_EMPTY), 32'd1);
    check("rst_read_data", UART_READ_DATA, 32'hFFFF_FFFF);
    check("rst_tx_busy", 32'(TX_BUSY), 32'd0);
    check("rst_tx_full", 32'(TX_FULL), 32'd0);
    check("rst_flags", {30'd0, RX_OVERRUN, FRAME_ERR}, 32'd0);

    // Single byte A5: cell pattern, latency and busy deassertion
    write_byte(8'hA5);
    t_wr = cyc;
    check("a5_pre_edge_tx", 32'(UART_TX), 32'd1);
    tx_frame("a5", cells, t_start);
    check("a5_latency", 32'(t_start - t_wr), 32'd1);
    exp_cells = {1'b1, 8'hA5, 1'b0};
    for (int i = 0; i < 10; i++)
      check($sformatf("a5_cell%0d", i), 32'(cells[i]), 32'(exp_cells[i]));
    @(negedge clk);
    check("a5_busy_last_cycle", 32'(TX_BUSY), 32'd1);
    @(negedge clk);
    check("a5_busy_after", 32'(TX_BUSY), 32'd0);
    check("a5_idle_line", 32'(UART_TX), 32'd1);

    // Five back-to-back bytes: order, 41-cycle frame spacing, FIFO full
    fork
      begin : writer
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          UART_WRITE_EN = 1'b1;
          TX_DATA = 8'(i + 1);
        end
        @(negedge clk);
        UART_WRITE_EN = 1'b0;
        check("b2b_tx_full", 32'(TX_FULL), 32'd1);
      end
      begin : capture
        logic [9:0] fc;
        int ts, tprev;
        tprev = 0;
        for (int i = 0; i < 5; i++) begin
          tx_frame($sformatf("b2b%0d", i), fc, ts);
          check($sformatf("b2b%0d_byte", i), 32'(fc[8:1]), 32'(i + 1));
          check($sformatf("b2b%0d_framing", i), {30'd0, fc[9], fc[0]}, 32'd2);
          if (i > 0) check($sformatf("b2b%0d_spacing", i), 32'(ts - tprev), 32'd41);
          tprev = ts;
        end
      end
    join
    repeat (4) @(negedge clk);
    check("b2b_busy_after", 32'(TX_BUSY), 32'd0);

`ifdef UART_LOOPBACK_EN
    // Loopback: TX traffic above also landed in RX; start clean
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    write_byte(8'h5A);
    repeat (70) @(negedge clk);
    check("lb_rx_empty", 32'(RX_EMPTY), 32'd0);
    check("lb_read_data", UART_READ_DATA, 32'h0000_005A);
    pop_rx();
    check("lb_pop_empty", 32'(RX_EMPTY), 32'd1);
`else
    // Single RX frame 3C, then pop
    rx_send(8'h3C, 1'b1);
    check("rx3c_empty", 32'(RX_EMPTY), 32'd0);
    check("rx3c_data", UART_READ_DATA, 32'h0000_003C);
    check("rx3c_no_err", {30'd0, RX_OVERRUN, FRAME_ERR}, 32'd0);
    pop_rx();
    check("rx3c_pop_empty", 32'(RX_EMPTY), 32'd1);
    check("rx3c_pop_data", UART_READ_DATA, 32'hFFFF_FFFF);

    // Five frames without reading: overrun, first four retained
    for (int i = 0; i < 5; i++) rx_send(8'(8'h11 * (i + 1)), 1'b1);
    check("ovr_flag", 32'(RX_OVERRUN), 32'd1);
    check("ovr_frame_err", 32'(FRAME_ERR), 32'd0);
    for (int i = 0; i < 4; i++) begin
      exp_b = 8'(8'h11 * (i + 1));
      check($sformatf("ovr_head%0d", i), UART_READ_DATA, {24'h0, exp_b});
      pop_rx();
    end
    check("ovr_drained", 32'(RX_EMPTY), 32'd1);
    check("ovr_sticky", 32'(RX_OVERRUN), 32'd1);
    clear_status();
    check("ovr_cleared", 32'(RX_OVERRUN), 32'd0);

    // Stop bit 0: framing error, byte discarded
    rx_send(8'h96, 1'b0);
    check("ferr_flag", 32'(FRAME_ERR), 32'd1);
    check("ferr_rx_empty", 32'(RX_EMPTY), 32'd1);
    clear_status();
    check("ferr_cleared", 32'(FRAME_ERR), 32'd0);
`endif

    // Reset mid-frame forces the line high at once
    write_byte(8'h00);
    repeat (10) @(negedge clk);
    check("midrst_pre_line", 32'(UART_TX), 32'd0);
    reset = 1'b1;
    #1;
    check("midrst_line", 32'(UART_TX), 32'd1);
    check("midrst_busy", 32'(TX_BUSY), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("midrst_line_after", 32'(UART_TX), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
